exec_sequencer: RTL and testbench
=================================

Name: exec_sequencer

Overview:
- Control unit for the single-cycle register-bank/ULA datapath on the DE2 board.
- Debounces the execute and view push-buttons and sequences one instruction per execute press: decode → execute → write-back.
- Drives the register-bank write enable, the view/operand mux select and the 7-segment blanking.
- Latches the ULA result for the HEX0–HEX3 display and counts retired instructions.

Parameters:
- WIDTH, 16, datapath/result width in bits.
- DBNC_CYCLES, 4, consecutive stable synchronized samples required before a button level change is accepted; minimum 1.
- CNT_W, 8, width of the retired-instruction counter.

Ports:
- CLK  in  1  system clock; all state on the rising edge.
- RST  in  1  asynchronous reset, active-high.
- exec_btn  in  1  raw execute button, active-high (inverted upstream), asynchronous to CLK.
- view_btn  in  1  raw view button, active-high, asynchronous to CLK.
- go  in  1  enable switch (SW17); synchronous level.
- instr_valid  in  1  decoder isValid, valid one cycle after the instruction switches are sampled.
- alu_res  in  WIDTH  ULA result.
- ready  out  1  sequencer idle and enabled.
- wen  out  1  register-bank write enable, one-cycle pulse.
- is_view  out  1  operand-address mux select: 1 = switch-selected view registers.
- idle_op  out  1  blank HEX0–HEX3 when 1.
- idle_view  out  1  blank HEX4–HEX7 when 1.
- result  out  WIDTH  latched write-back value.
- illegal  out  1  last execute attempt decoded invalid.
- exec_count  out  CNT_W  retired-instruction count.

Behaviour:
- Reset values:
  - ready=0, wen=0, is_view=0, idle_op=1, idle_view=1.
  - result=0, illegal=0, exec_count=0.
  - FSM in IDLE; debouncers cleared (level 0).
- Outputs are registered. RST asserted mid-operation aborts immediately, with no further wen.
- Debounce: 2-flop synchronizer, then a counter.
  - The accepted level changes only after DBNC_CYCLES consecutive equal samples that differ from the current level.
  - exec_rise is a one-cycle pulse on an accepted 0→1 change.
  - view_lvl is the accepted level of the view button.
  - Button-to-event latency is 2+DBNC_CYCLES cycles.
- States: IDLE, DECODE, EXEC, WB, HOLD, ERR, VIEW.
- IDLE:
  - ready=1 iff go=1.
  - exec_rise & go & ~view_lvl → DECODE.
  - view_lvl & ~exec_lvl → VIEW.
  - Both levels high → stay in IDLE.
  - exec_rise while go=0 is dropped and not queued.
- DECODE (1 cycle):
  - instr_valid=1 → EXEC and clear illegal.
  - instr_valid=0 → ERR and set illegal.
- EXEC (1 cycle): operands and ALU settle; go to WB.
- WB (1 cycle):
  - wen=1 during this cycle.
  - result←alu_res at the end of the cycle.
  - exec_count←exec_count+1, wrapping at 2^CNT_W−1 → 0.
  - → HOLD.
- Timing: if exec_rise is seen in cycle n, wen is high in cycle n+3 and the new result is visible in cycle n+4.
- HOLD: idle_op=0; wait for exec_lvl=0, then → IDLE. Re-presses while held are impossible; new rises are ignored until IDLE.
- ERR: idle_op=0, no wen, result unchanged; on exec_lvl=0 → IDLE.
- Display blanking:
  - idle_op=0 in DECODE, EXEC, WB, HOLD, ERR; 1 otherwise.
  - idle_view=0 only in VIEW.
- VIEW:
  - is_view=1, idle_view=0, wen=0.
  - exec_rise is ignored.
  - view_lvl=0 → IDLE.
- go dropping mid-sequence does not abort it; it only gates acceptance in IDLE.
- ready is 0 in every state except IDLE.

Decomposition:
- Package exec_seq_pkg holds:
  - the state enum (7 states, 3-bit encoding);
  - default WIDTH/DBNC_CYCLES/CNT_W constants.
- One sub-module, btn_debounce: synchronizer plus counter, with outputs lvl and rise.
  - Instantiate it twice, once for exec and once for view.

Test Plan:
- Reset, then go=1, exec press held for 20 cycles, instr_valid=1, alu_res=16'h00A5 → wen high exactly once, at 3 cycles after exec_rise; result=16'h00A5; exec_count=1; idle_op=0 until release; ready=1 again after release.
- Button bouncing 1/0 every cycle for 3 cycles, then stable high, with DBNC_CYCLES=4 → exactly one DECODE entry and one wen pulse.
- instr_valid=0 on press → illegal=1, no wen, result keeps its previous value.
  - Next valid press → illegal=0, wen pulses once.
- go=0 with exec press → ready=0, no state change, no wen; raising go later without a new press causes no execution.
- view pressed → is_view=1, idle_view=0, idle_op=1.
  - exec pressed during VIEW → no wen.
  - Both released → IDLE.
  - Both pressed simultaneously from IDLE → stays in IDLE.
- RST asserted during EXEC → all outputs at reset values within the same cycle (asynchronous), no wen; 256 valid executions → exec_count wraps to 0.

Source files
------------

// File: rtl/exec_seq_pkg.sv
// -----------------------------------------------------------------------------
// exec_seq_pkg
// Shared definitions for the exec_sequencer control unit:
//   - default parameter values for datapath width, debounce length and
//     retired-instruction counter width
//   - the sequencer state enum (7 states, 3-bit encoding)
//   - a helper that tells whether a state belongs to an instruction in flight
// -----------------------------------------------------------------------------
package exec_seq_pkg;

  localparam int DEF_WIDTH       = 16;
  localparam int DEF_DBNC_CYCLES = 4;
  localparam int DEF_CNT_W       = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_WB     = 3'd3,
    ST_HOLD   = 3'd4,
    ST_ERR    = 3'd5,
    ST_VIEW   = 3'd6
  } seq_state_e;

  // True while an execute press is being processed or held; the operand
  // display is lit in exactly these states.
  function automatic logic opActive(input seq_state_e s);
    return (s == ST_DECODE) || (s == ST_EXEC) || (s == ST_WB) ||
           (s == ST_HOLD)   || (s == ST_ERR);
  endfunction

endpackage

// File: rtl/exec_sequencer_if.sv
// -----------------------------------------------------------------------------
// exec_sequencer_if
// Bundles the board-side signals of the sequencer.
//   master : board / stimulus side (drives buttons, switches, decoder, ULA)
//   slave  : sequencer side (drives write enable, mux select, blanking,
//            latched result, illegal flag and retired count)
// Signals:
//   exec_btn, view_btn : raw push-buttons, active-high, asynchronous
//   go                 : enable switch, synchronous level
//   instr_valid        : decoder valid flag
//   alu_res            : ULA result
//   ready, wen, is_view, idle_op, idle_view, result, illegal, exec_count
// -----------------------------------------------------------------------------
interface exec_sequencer_if
  import exec_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
);

  logic             exec_btn;
  logic             view_btn;
  logic             go;
  logic             instr_valid;
  logic [WIDTH-1:0] alu_res;

  logic             ready;
  logic             wen;
  logic             is_view;
  logic             idle_op;
  logic             idle_view;
  logic [WIDTH-1:0] result;
  logic             illegal;
  logic [CNT_W-1:0] exec_count;

  modport master (
    output exec_btn, view_btn, go, instr_valid, alu_res,
    input  ready, wen, is_view, idle_op, idle_view, result, illegal, exec_count
  );

  modport slave (
    input  exec_btn, view_btn, go, instr_valid, alu_res,
    output ready, wen, is_view, idle_op, idle_view, result, illegal, exec_count
  );

endinterface

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Two-flop synchronizer followed by a stability counter. The accepted level
// only moves after DBNC_CYCLES consecutive synchronized samples that all
// differ from it; any sample equal to the current level restarts the count.
// Ports:
//   clk, rst : clock and asynchronous active-high reset
//   btn_i    : raw button, asynchronous to clk
//   lvl_o    : accepted (debounced) level
//   rise_o   : one-cycle pulse on an accepted 0->1 change
// -----------------------------------------------------------------------------
module btn_debounce
  import exec_seq_pkg::*;
#(
  parameter int DBNC_CYCLES = DEF_DBNC_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic lvl_o,
  output logic rise_o
);

  localparam int            CW   = (DBNC_CYCLES > 1) ? $clog2(DBNC_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DBNC_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          lvl_q, lvl_d;
  logic          rise_q, rise_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Stability counter: counts differing samples; the sample that would make
  // the count reach DBNC_CYCLES commits the new level instead of counting.
  always_comb begin
    cnt_d  = '0;
    lvl_d  = lvl_q;
    rise_d = 1'b0;
    if (sync2_q != lvl_q) begin
      if (cnt_q == LAST) begin
        lvl_d  = sync2_q;
        rise_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Synchronizer chain and debounce state; reset clears to level 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      lvl_q   <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      lvl_q   <= lvl_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign lvl_o  = lvl_q;
  assign rise_o = rise_q;

endmodule

// File: rtl/exec_sequencer.sv
// -----------------------------------------------------------------------------
// exec_sequencer
// Control unit for the single-cycle register-bank/ULA datapath. Each accepted
// execute press runs DECODE -> EXEC -> WB, pulsing the register-bank write
// enable in WB, latching the ULA result and counting retired instructions.
// The view button switches the operand mux to the view registers.
// Ports:
//   CLK, RST : clock and asynchronous active-high reset
//   bus      : slave modport of exec_sequencer_if (buttons, go, instr_valid,
//              alu_res in; ready, wen, is_view, idle_op, idle_view, result,
//              illegal, exec_count out). All outputs are registered.
// -----------------------------------------------------------------------------
module exec_sequencer
  import exec_seq_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int DBNC_CYCLES = DEF_DBNC_CYCLES,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic              CLK,
  input  logic              RST,
  exec_sequencer_if.slave   bus
);

  seq_state_e       state_q, state_d;

  logic             execLvl, execRise;
  logic             viewLvl, viewRiseUnused;

  logic             ready_q, ready_d;
  logic             wen_q, wen_d;
  logic             isView_q, isView_d;
  logic             idleOp_q, idleOp_d;
  logic             idleView_q, idleView_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] execCount_q, execCount_d;

  btn_debounce #(.DBNC_CYCLES(DBNC_CYCLES)) uExecDbnc (
    .clk    (CLK),
    .rst    (RST),
    .btn_i  (bus.exec_btn),
    .lvl_o  (execLvl),
    .rise_o (execRise)
  );

  btn_debounce #(.DBNC_CYCLES(DBNC_CYCLES)) uViewDbnc (
    .clk    (CLK),
    .rst    (RST),
    .btn_i  (bus.view_btn),
    .lvl_o  (viewLvl),
    .rise_o (viewRiseUnused)
  );

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. An execute rise is only honoured in IDLE with go high
  // and view released; rises anywhere else are simply lost, not queued.
  // Both buttons held together keeps the sequencer parked in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (execRise && bus.go && !viewLvl) begin
          state_d = ST_DECODE;
        end else if (viewLvl && !execLvl) begin
          state_d = ST_VIEW;
        end
      end
      ST_DECODE: state_d = bus.instr_valid ? ST_EXEC : ST_ERR;
      ST_EXEC:   state_d = ST_WB;
      ST_WB:     state_d = ST_HOLD;
      ST_HOLD,
      ST_ERR: begin
        if (!execLvl) begin
          state_d = ST_IDLE;
        end
      end
      ST_VIEW: begin
        if (!viewLvl) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic. Status outputs are decoded from the next state so the
  // registered copies line up with the state they describe; result, count
  // and illegal update at the end of the WB / DECODE cycles.
  always_comb begin
    ready_d     = (state_d == ST_IDLE) && bus.go;
    wen_d       = (state_d == ST_WB);
    isView_d    = (state_d == ST_VIEW);
    idleOp_d    = !opActive(state_d);
    idleView_d  = (state_d != ST_VIEW);
    result_d    = result_q;
    execCount_d = execCount_q;
    illegal_d   = illegal_q;
    if (state_q == ST_DECODE) begin
      illegal_d = !bus.instr_valid;
    end
    if (state_q == ST_WB) begin
      result_d    = bus.alu_res;
      execCount_d = execCount_q + 1'b1;
    end
  end

  // Output registers; reset blanks both displays and drops wen at once.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ready_q     <= 1'b0;
      wen_q       <= 1'b0;
      isView_q    <= 1'b0;
      idleOp_q    <= 1'b1;
      idleView_q  <= 1'b1;
      result_q    <= '0;
      illegal_q   <= 1'b0;
      execCount_q <= '0;
    end else begin
      ready_q     <= ready_d;
      wen_q       <= wen_d;
      isView_q    <= isView_d;
      idleOp_q    <= idleOp_d;
      idleView_q  <= idleView_d;
      result_q    <= result_d;
      illegal_q   <= illegal_d;
      execCount_q <= execCount_d;
    end
  end

  assign bus.ready      = ready_q;
  assign bus.wen        = wen_q;
  assign bus.is_view    = isView_q;
  assign bus.idle_op    = idleOp_q;
  assign bus.idle_view  = idleView_q;
  assign bus.result     = result_q;
  assign bus.illegal    = illegal_q;
  assign bus.exec_count = execCount_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// -----------------------------------------------------------------------------
// tb_exec_sequencer
// Directed bench for exec_sequencer with DBNC_CYCLES=4. Inputs are driven on
// the falling edge and outputs are sampled there as well.
// -----------------------------------------------------------------------------
module tb_exec_sequencer;

  logic clk;
  logic rst;
  int   checks;
  int   passed;
  int   wenCount;
  int   wenBase;

  exec_sequencer_if #(.WIDTH(16), .CNT_W(8)) bus ();

  exec_sequencer #(.WIDTH(16), .DBNC_CYCLES(4), .CNT_W(8)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  // Free-running 10 time-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Counts every cycle in which the write enable is high.
  always @(negedge clk) begin
    if (bus.wen === 1'b1) wenCount++;
  end

  // Hard stop in case something wedges the stimulus.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic stepCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One full valid execution: press, let it retire, release, back to IDLE.
  task automatic applyStimulus(input logic [15:0] value);
    bus.alu_res  = value;
    bus.exec_btn = 1'b1;
    stepCycles(12);
    bus.exec_btn = 1'b0;
    stepCycles(10);
  endtask

  initial begin
    checks       = 0;
    passed       = 0;
    wenCount     = 0;
    rst          = 1'b1;
    bus.exec_btn = 1'b0;
    bus.view_btn = 1'b0;
    bus.go       = 1'b0;
    bus.instr_valid = 1'b0;
    bus.alu_res  = 16'h0000;
    stepCycles(3);

    // Reset values
    checkOutput("rst_ready",     32'(bus.ready),      32'h0);
    checkOutput("rst_wen",       32'(bus.wen),        32'h0);
    checkOutput("rst_is_view",   32'(bus.is_view),    32'h0);
    checkOutput("rst_idle_op",   32'(bus.idle_op),    32'h1);
    checkOutput("rst_idle_view", 32'(bus.idle_view),  32'h1);
    checkOutput("rst_result",    32'(bus.result),     32'h0);
    checkOutput("rst_illegal",   32'(bus.illegal),    32'h0);
    checkOutput("rst_count",     32'(bus.exec_count), 32'h0);

    rst    = 1'b0;
    bus.go = 1'b1;
    stepCycles(3);
    checkOutput("idle_ready", 32'(bus.ready), 32'h1);

    // Basic execution: rise 6 cycles after press, wen 3 cycles later
    $display("[TB] basic execution");
    wenBase         = wenCount;
    bus.instr_valid = 1'b1;
    bus.alu_res     = 16'h00A5;
    bus.exec_btn    = 1'b1;
    stepCycles(8);
    checkOutput("t1_wen_early", 32'(bus.wen), 32'h0);
    stepCycles(1);
    checkOutput("t1_wen_on",   32'(bus.wen),     32'h1);
    checkOutput("t1_idle_op",  32'(bus.idle_op), 32'h0);
    checkOutput("t1_ready_busy", 32'(bus.ready), 32'h0);
    stepCycles(1);
    checkOutput("t1_wen_off", 32'(bus.wen),        32'h0);
    checkOutput("t1_result",  32'(bus.result),     32'h00A5);
    checkOutput("t1_count",   32'(bus.exec_count), 32'h1);
    stepCycles(10);
    checkOutput("t1_hold_idle_op", 32'(bus.idle_op), 32'h0);
    bus.exec_btn = 1'b0;
    stepCycles(10);
    checkOutput("t1_rel_ready",   32'(bus.ready),    32'h1);
    checkOutput("t1_rel_idle_op", 32'(bus.idle_op),  32'h1);
    checkOutput("t1_wen_pulses",  32'(wenCount - wenBase), 32'h1);

    // Bouncing press: 1,0,1 then stable high
    $display("[TB] bouncing press");
    wenBase      = wenCount;
    bus.alu_res  = 16'h1234;
    bus.exec_btn = 1'b1;
    stepCycles(1);
    bus.exec_btn = 1'b0;
    stepCycles(1);
    bus.exec_btn = 1'b1;
    stepCycles(20);
    checkOutput("t2_wen_pulses", 32'(wenCount - wenBase), 32'h1);
    checkOutput("t2_result",     32'(bus.result),         32'h1234);
    checkOutput("t2_count",      32'(bus.exec_count),     32'h2);
    checkOutput("t2_idle_op",    32'(bus.idle_op),        32'h0);
    bus.exec_btn = 1'b0;
    stepCycles(10);
    checkOutput("t2_rel_ready", 32'(bus.ready), 32'h1);

    // Invalid instruction, then a valid one
    $display("[TB] illegal instruction");
    wenBase         = wenCount;
    bus.instr_valid = 1'b0;
    bus.alu_res     = 16'hBEEF;
    bus.exec_btn    = 1'b1;
    stepCycles(12);
    checkOutput("t3_illegal",   32'(bus.illegal),        32'h1);
    checkOutput("t3_no_wen",    32'(wenCount - wenBase), 32'h0);
    checkOutput("t3_result",    32'(bus.result),         32'h1234);
    checkOutput("t3_err_idle_op", 32'(bus.idle_op),      32'h0);
    bus.exec_btn = 1'b0;
    stepCycles(10);
    checkOutput("t3_rel_ready", 32'(bus.ready), 32'h1);
    bus.instr_valid = 1'b1;
    bus.alu_res     = 16'h0042;
    bus.exec_btn    = 1'b1;
    stepCycles(12);
    checkOutput("t3b_illegal", 32'(bus.illegal),        32'h0);
    checkOutput("t3b_wen",     32'(wenCount - wenBase), 32'h1);
    checkOutput("t3b_result",  32'(bus.result),         32'h0042);
    checkOutput("t3b_count",   32'(bus.exec_count),     32'h3);
    bus.exec_btn = 1'b0;
    stepCycles(10);

    // go low: press is dropped, raising go later does nothing
    $display("[TB] go disabled");
    wenBase = wenCount;
    bus.go  = 1'b0;
    stepCycles(2);
    checkOutput("t4_ready_low", 32'(bus.ready), 32'h0);
    bus.exec_btn = 1'b1;
    stepCycles(12);
    checkOutput("t4_idle_op", 32'(bus.idle_op),        32'h1);
    checkOutput("t4_no_wen",  32'(wenCount - wenBase), 32'h0);
    bus.go = 1'b1;
    stepCycles(10);
    checkOutput("t4_go_no_wen", 32'(wenCount - wenBase), 32'h0);
    checkOutput("t4_go_idle_op", 32'(bus.idle_op),       32'h1);
    checkOutput("t4_go_ready",  32'(bus.ready),          32'h1);
    checkOutput("t4_count",     32'(bus.exec_count),     32'h3);
    bus.exec_btn = 1'b0;
    stepCycles(10);

    // View mode
    $display("[TB] view mode");
    wenBase      = wenCount;
    bus.view_btn = 1'b1;
    stepCycles(10);
    checkOutput("t5_is_view",   32'(bus.is_view),   32'h1);
    checkOutput("t5_idle_view", 32'(bus.idle_view), 32'h0);
    checkOutput("t5_idle_op",   32'(bus.idle_op),   32'h1);
    checkOutput("t5_ready",     32'(bus.ready),     32'h0);
    bus.exec_btn = 1'b1;
    stepCycles(12);
    checkOutput("t5_exec_no_wen", 32'(wenCount - wenBase), 32'h0);
    checkOutput("t5_still_view",  32'(bus.is_view),        32'h1);
    bus.view_btn = 1'b0;
    stepCycles(10);
    checkOutput("t5_rel_is_view",   32'(bus.is_view),   32'h0);
    checkOutput("t5_rel_idle_view", 32'(bus.idle_view), 32'h1);
    checkOutput("t5_rel_ready",     32'(bus.ready),     32'h1);
    bus.exec_btn = 1'b0;
    stepCycles(10);
    checkOutput("t5_after_no_wen", 32'(wenCount - wenBase), 32'h0);

    // Both buttons together from IDLE
    bus.exec_btn = 1'b1;
    bus.view_btn = 1'b1;
    stepCycles(12);
    checkOutput("t5b_is_view", 32'(bus.is_view),        32'h0);
    checkOutput("t5b_idle_op", 32'(bus.idle_op),        32'h1);
    checkOutput("t5b_ready",   32'(bus.ready),          32'h1);
    checkOutput("t5b_no_wen",  32'(wenCount - wenBase), 32'h0);
    bus.exec_btn = 1'b0;
    bus.view_btn = 1'b0;
    stepCycles(10);

    // Asynchronous reset while in EXEC
    $display("[TB] reset during EXEC");
    wenBase      = wenCount;
    bus.alu_res  = 16'h7777;
    bus.exec_btn = 1'b1;
    stepCycles(8);
    #2 rst = 1'b1;
    #1;
    checkOutput("t6_wen",     32'(bus.wen),        32'h0);
    checkOutput("t6_result",  32'(bus.result),     32'h0);
    checkOutput("t6_count",   32'(bus.exec_count), 32'h0);
    checkOutput("t6_idle_op", 32'(bus.idle_op),    32'h1);
    checkOutput("t6_ready",   32'(bus.ready),      32'h0);
    checkOutput("t6_illegal", 32'(bus.illegal),    32'h0);
    bus.exec_btn = 1'b0;
    stepCycles(3);
    rst = 1'b0;
    stepCycles(12);
    checkOutput("t6_no_wen",     32'(wenCount - wenBase), 32'h0);
    checkOutput("t6_post_result", 32'(bus.result),        32'h0);
    checkOutput("t6_post_ready", 32'(bus.ready),          32'h1);

    // Counter wrap after 256 retirements
    $display("[TB] counter wrap");
    wenBase = wenCount;
    for (int i = 1; i <= 255; i++) begin
      applyStimulus(16'(i));
    end
    checkOutput("t7_count_255", 32'(bus.exec_count), 32'hFF);
    checkOutput("t7_result_255", 32'(bus.result),    32'h00FF);
    applyStimulus(16'hC0DE);
    checkOutput("t7_count_wrap", 32'(bus.exec_count),     32'h0);
    checkOutput("t7_result",     32'(bus.result),         32'hC0DE);
    checkOutput("t7_wen_total",  32'(wenCount - wenBase), 32'd256);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
